// File: rtl/rvpipe_pkg.sv
// ============================================================================
// rvpipe_pkg : shared forward-select codes and hazard FSM state encoding
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rvpipe_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LDSTALL = 2'd1,
    MCBUSY  = 2'd2
  } hz_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_mc_if.sv
// ============================================================================
// hazard_unit_mc_if : datapath <-> hazard unit signal bundle
// Revision          : 1.0
// ============================================================================
`default_nettype none

interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 16
);

  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic              PCSrcE;
  logic              ResultSrcb0E;
  logic              McStartE;
  logic              RegWriteM;
  logic              RegWriteW;

  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              McBusy;
  logic [PERF_W-1:0] StallCount;

  // Datapath side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           PCSrcE, ResultSrcb0E, McStartE, RegWriteM, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, McBusy, StallCount
  );

  // Hazard unit side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           PCSrcE, ResultSrcb0E, McStartE, RegWriteM, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, McBusy, StallCount
  );

endinterface

`default_nettype wire

// File: rtl/hazard_unit_mc_fwd_sel.sv
// ============================================================================
// fwd_sel : per-operand forwarding source select (M beats W, x0 never forwards)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_sel
  import rvpipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  wire logic [REG_AW-1:0] i_rs,
  input  wire logic [REG_AW-1:0] i_rd_m,
  input  wire logic [REG_AW-1:0] i_rd_w,
  input  wire logic              i_regwrite_m,
  input  wire logic              i_regwrite_w,
  output logic [1:0]             o_fwd
);

  logic w_rs_nz;

  assign w_rs_nz = |i_rs;

  always_comb begin
    o_fwd = FWD_RF;
    if (w_rs_nz && i_regwrite_m && (i_rs == i_rd_m)) begin
      o_fwd = FWD_M;
    end else if (w_rs_nz && i_regwrite_w && (i_rs == i_rd_w)) begin
      o_fwd = FWD_W;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit_mc.sv
// ============================================================================
// hazard_unit_mc : forwarding, load-use / multi-cycle stall, branch flush and
//                  saturating stall-cycle counter for the rvpipe 5-stage core
// Revision       : 1.0
// ============================================================================
`default_nettype none

module hazard_unit_mc
  import rvpipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4,
  parameter int PERF_W   = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  hazard_unit_mc_if.slave hz
);

  localparam int LDW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int MCW = $clog2(MC_LAT);

  localparam logic [LDW-1:0] c_LD_INIT = LDW'(LOAD_LAT - 1);
  localparam logic [MCW-1:0] c_MC_INIT = MCW'(MC_LAT - 2);
  localparam logic [LDW-1:0] c_LD_LAST = LDW'(1);

  hz_state_e         r_state;
  logic [LDW-1:0]    r_ldcnt;
  logic [MCW-1:0]    r_mccnt;
  logic [PERF_W-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_stall_f;
  logic w_stall_d;
  logic w_stall_e;
  logic w_flush_d;
  logic w_flush_e;
  logic w_flush_m;
  logic w_mc_busy;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs         (hz.Rs1E),
    .i_rd_m       (hz.RdM),
    .i_rd_w       (hz.RdW),
    .i_regwrite_m (hz.RegWriteM),
    .i_regwrite_w (hz.RegWriteW),
    .o_fwd        (hz.ForwardAE)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs         (hz.Rs2E),
    .i_rd_m       (hz.RdM),
    .i_rd_w       (hz.RdW),
    .i_regwrite_m (hz.RegWriteM),
    .i_regwrite_w (hz.RegWriteW),
    .o_fwd        (hz.ForwardBE)
  );

  assign w_load_use = hz.ResultSrcb0E && (hz.RdE != '0) &&
                      ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  // Stall/flush must act in the cycle the hazard is seen, so they decode
  // the current state and inputs rather than being registered.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    w_mc_busy = 1'b0;
    case (r_state)
      IDLE: begin
        if (hz.PCSrcE) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (hz.McStartE) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_flush_m = 1'b1;
          w_mc_busy = 1'b1;
        end else if (w_load_use) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end
      LDSTALL: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
      MCBUSY: begin
        if (r_mccnt != '0) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_flush_m = 1'b1;
          w_mc_busy = 1'b1;
        end
      end
      default: begin
        w_stall_f = 1'b0;
      end
    endcase
  end

  // Gating with rst_n keeps the controls quiet during reset even if the
  // datapath is still presenting a hazard.
  assign hz.StallF     = w_stall_f & rst_n;
  assign hz.StallD     = w_stall_d & rst_n;
  assign hz.StallE     = w_stall_e & rst_n;
  assign hz.FlushD     = w_flush_d & rst_n;
  assign hz.FlushE     = w_flush_e & rst_n;
  assign hz.FlushM     = w_flush_m & rst_n;
  assign hz.McBusy     = w_mc_busy & rst_n;
  assign hz.StallCount = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ldcnt <= '0;
      r_mccnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!hz.PCSrcE) begin
            if (hz.McStartE) begin
              r_mccnt <= c_MC_INIT;
              r_state <= MCBUSY;
            end else if (w_load_use && (LOAD_LAT > 1)) begin
              r_ldcnt <= c_LD_INIT;
              r_state <= LDSTALL;
            end
          end
        end
        LDSTALL: begin
          r_ldcnt <= r_ldcnt - 1'b1;
          if (r_ldcnt == c_LD_LAST) begin
            r_state <= IDLE;
          end
        end
        MCBUSY: begin
          if (r_mccnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_mccnt <= r_mccnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_f && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
// ============================================================================
// tb_hazard_unit_mc : two configurations (LOAD_LAT=1/PERF_W=16 and
//                     LOAD_LAT=3/PERF_W=4) driven in lock-step, scoreboarded
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_unit_mc;

  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] LU = 7'b1100100;
  localparam logic [6:0] MC = 7'b1110011;
  localparam logic [6:0] BR = 7'b0001100;

  logic clk;
  logic rst_n;

  hazard_unit_mc_if #(.REG_AW(5), .PERF_W(16)) if_a ();
  hazard_unit_mc_if #(.REG_AW(5), .PERF_W(4))  if_b ();

  hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(1), .MC_LAT(4), .PERF_W(16)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_a)
  );

  hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(3), .MC_LAT(4), .PERF_W(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_b)
  );

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       pcsrc, ld, mc, rwm, rww;
  } stim_t;

  typedef struct {
    logic [1:0]  fa, fb;
    logic [6:0]  fl_a, fl_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  stim_t s;
  exp_t  sb[$];
  int    ec_a, ec_b;
  int    total, bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    s.rs1d = '0; s.rs2d = '0; s.rs1e = '0; s.rs2e = '0;
    s.rde = '0;  s.rdm = '0;  s.rdw = '0;
    s.pcsrc = 1'b0; s.ld = 1'b0; s.mc = 1'b0; s.rwm = 1'b0; s.rww = 1'b0;
  endtask

  task automatic apply();
    rst_n = s.rst_n;
    if_a.Rs1D = s.rs1d; if_a.Rs2D = s.rs2d; if_a.Rs1E = s.rs1e; if_a.Rs2E = s.rs2e;
    if_a.RdE = s.rde;   if_a.RdM = s.rdm;   if_a.RdW = s.rdw;
    if_a.PCSrcE = s.pcsrc; if_a.ResultSrcb0E = s.ld; if_a.McStartE = s.mc;
    if_a.RegWriteM = s.rwm; if_a.RegWriteW = s.rww;
    if_b.Rs1D = s.rs1d; if_b.Rs2D = s.rs2d; if_b.Rs1E = s.rs1e; if_b.Rs2E = s.rs2e;
    if_b.RdE = s.rde;   if_b.RdM = s.rdm;   if_b.RdW = s.rdw;
    if_b.PCSrcE = s.pcsrc; if_b.ResultSrcb0E = s.ld; if_b.McStartE = s.mc;
    if_b.RegWriteM = s.rwm; if_b.RegWriteW = s.rww;
  endtask

  // Apply one cycle of stimulus and queue what both DUTs should show in it.
  task automatic step(input logic [1:0] fa, input logic [1:0] fb,
                      input logic [6:0] fl_a, input logic [6:0] fl_b);
    exp_t e;
    @(posedge clk);
    #1;
    apply();
    if (!s.rst_n) begin
      ec_a = 0;
      ec_b = 0;
    end
    e.fa = fa; e.fb = fb; e.fl_a = fl_a; e.fl_b = fl_b;
    e.cnt_a = 16'(ec_a);
    e.cnt_b = 4'(ec_b);
    sb.push_back(e);
    if (fl_a[6] && ec_a < 65535) ec_a++;
    if (fl_b[6] && ec_b < 15) ec_b++;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("a_fwdA", int'(if_a.ForwardAE), int'(e.fa));
      chk("a_fwdB", int'(if_a.ForwardBE), int'(e.fb));
      chk("a_ctrl", int'({if_a.StallF, if_a.StallD, if_a.StallE, if_a.FlushD,
                          if_a.FlushE, if_a.FlushM, if_a.McBusy}), int'(e.fl_a));
      chk("a_cnt",  int'(if_a.StallCount), int'(e.cnt_a));
      chk("b_fwdA", int'(if_b.ForwardAE), int'(e.fa));
      chk("b_fwdB", int'(if_b.ForwardBE), int'(e.fb));
      chk("b_ctrl", int'({if_b.StallF, if_b.StallD, if_b.StallE, if_b.FlushD,
                          if_b.FlushE, if_b.FlushM, if_b.McBusy}), int'(e.fl_b));
      chk("b_cnt",  int'(if_b.StallCount), int'(e.cnt_b));
    end
  end

  initial begin
    total = 0; bad = 0; ec_a = 0; ec_b = 0;
    clr();
    s.rst_n = 1'b0;
    apply();

    // Reset state; forwarding stays live during reset
    s.rs1e = 5; s.rdm = 5; s.rwm = 1;
    step(2'b10, 2'b00, Z, Z);

    // Forwarding priority and qualification
    s.rst_n = 1'b1;
    s.rs1e = 5; s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1;
    step(2'b10, 2'b00, Z, Z);
    s.rwm = 0;
    step(2'b01, 2'b00, Z, Z);
    s.rs1e = 0;
    step(2'b00, 2'b00, Z, Z);
    s.rs1e = 5; s.rs2e = 6; s.rdm = 6; s.rwm = 1; s.rdw = 5; s.rww = 1;
    step(2'b01, 2'b10, Z, Z);

    // Load-use via Rs2D
    clr(); s.ld = 1; s.rde = 7; s.rs2d = 7;
    step(2'b00, 2'b00, LU, LU);
    clr();
    step(2'b00, 2'b00, Z, LU);
    step(2'b00, 2'b00, Z, LU);
    step(2'b00, 2'b00, Z, Z);

    // x0 destination never stalls
    s.ld = 1; s.rde = 0;
    step(2'b00, 2'b00, Z, Z);

    // Load-use via Rs1D
    clr(); s.ld = 1; s.rde = 3; s.rs1d = 3;
    step(2'b00, 2'b00, LU, LU);
    clr();
    step(2'b00, 2'b00, Z, LU);
    step(2'b00, 2'b00, Z, LU);
    step(2'b00, 2'b00, Z, Z);

    // Register match without a load is not a hazard
    s.rde = 3; s.rs1d = 3;
    step(2'b00, 2'b00, Z, Z);

    // Multi-cycle op; repeated McStartE while busy is ignored
    clr(); s.mc = 1;
    step(2'b00, 2'b00, MC, MC);
    step(2'b00, 2'b00, MC, MC);
    s.mc = 0;
    step(2'b00, 2'b00, MC, MC);
    s.mc = 1;
    step(2'b00, 2'b00, Z, Z);
    s.mc = 0;
    step(2'b00, 2'b00, Z, Z);

    // Branch beats McStartE and load-use
    s.pcsrc = 1; s.mc = 1; s.ld = 1; s.rde = 7; s.rs2d = 7;
    step(2'b00, 2'b00, BR, BR);
    clr();
    step(2'b00, 2'b00, Z, Z);

    // Reset in the middle of a multi-cycle op
    s.mc = 1;
    step(2'b00, 2'b00, MC, MC);
    s.mc = 0;
    step(2'b00, 2'b00, MC, MC);
    s.rst_n = 1'b0;
    step(2'b00, 2'b00, Z, Z);
    s.rst_n = 1'b1;
    step(2'b00, 2'b00, Z, Z);
    step(2'b00, 2'b00, Z, Z);

    // 20 load-use events: B saturates at 15, A counts on
    for (int k = 0; k < 20; k++) begin
      clr(); s.ld = 1; s.rde = 7; s.rs2d = 7;
      step(2'b00, 2'b00, LU, LU);
      clr();
      step(2'b00, 2'b00, Z, LU);
      step(2'b00, 2'b00, Z, LU);
    end
    step(2'b00, 2'b00, Z, Z);
    step(2'b00, 2'b00, Z, Z);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Pipeline hazard controller for the rvpipe 5-stage core. It extends the combinational forwarding/stall/flush logic with sequential control:
- multi-cycle execute ops (mul/div) handled by a busy counter;
- configurable load-use latency for slow data memory;
- a saturating stall-cycle performance counter.

It sits beside the datapath and drives the F/D/E/M pipeline-register enables and clears.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 1, stall cycles inserted per load-use hazard (>=1)
MC_LAT, 4, total E-stage cycles of a multi-cycle op (>=2)
PERF_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D  in  REG_AW  source regs in Decode
Rs1E, Rs2E, RdE  in  REG_AW  source/dest regs in Execute
PCSrcE  in  1  taken branch/jump resolved in E
ResultSrcb0E  in  1  E instruction is a load
McStartE  in  1  E instruction is a multi-cycle op
RdM, RdW  in  REG_AW  dest regs in Memory/Writeback
RegWriteM, RegWriteW  in  1  write enables in M/W
ForwardAE, ForwardBE  out  2  forward select: 00 regfile, 01 W, 10 M
StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX registers
FlushD, FlushE, FlushM  out  1  clear IF-ID / ID-EX / EX-MEM registers
McBusy  out  1  multi-cycle op in progress
StallCount  out  PERF_W  saturating count of cycles with StallF=1

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, counters=0, StallCount=0; all stall/flush outputs 0; McBusy=0. Forward outputs remain combinational.
- Forwarding (combinational):
  - M has priority over W.
  - Match requires RegWrite=1 and Rs!=0.
  - Forwarding is identical for A (Rs1E) and B (Rs2E).
- FSM states: IDLE, LDSTALL, MCBUSY.
- IDLE:
  - Load-use: ResultSrcb0E=1, RdE!=0, and (Rs1D==RdE or Rs2D==RdE), with PCSrcE=0.
  - On load-use: assert StallF, StallD, FlushE this cycle. If LOAD_LAT>1, load ldcnt=LOAD_LAT-1 and go LDSTALL.
  - Multi-cycle op: McStartE=1 and PCSrcE=0. Assert StallF, StallD, StallE, FlushM and McBusy this cycle; load mccnt=MC_LAT-2; go MCBUSY.
- LDSTALL:
  - Assert StallF, StallD, FlushE; decrement ldcnt.
  - Return to IDLE in the cycle ldcnt is 1.
  - Total stall cycles = LOAD_LAT.
- MCBUSY:
  - Assert StallF, StallD, StallE, FlushM, McBusy.
  - When mccnt==0, deassert all of them this cycle (result advances) and go IDLE; otherwise decrement.
  - Total stalled cycles = MC_LAT-1.
  - McStartE is ignored while in MCBUSY.
- Branch:
  - PCSrcE=1 in IDLE: FlushD=1, FlushE=1, no stall.
  - PCSrcE overrides a coincident load-use or McStartE; the E instruction is a branch, so the two cannot both be legitimate.
- Priority in IDLE: PCSrcE > McStartE > load-use.
- x0 is never a hazard source: RdE==0 never causes a stall.
- StallCount: +1 every cycle StallF=1; saturates at all-ones and does not wrap.
- Reset mid-op: immediate return to IDLE with outputs deasserted in the same cycle (async).

Decomposition:
- Shared package rvpipe_pkg holds:
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - the FSM state enum.
- Forwarding comparator is a natural sub-module, fwd_sel (instantiated twice for A/B).
- Counters and FSM stay in the top.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then Rs1E=0 -> ForwardAE=00.
- Load-use, LOAD_LAT=1 vs 3: ResultSrcb0E=1, RdE=7, Rs2D=7:
  - LOAD_LAT=1 -> exactly 1 cycle StallF=StallD=FlushE=1.
  - LOAD_LAT=3 -> exactly 3 consecutive cycles, then 0.
  - StallCount advances by 1 and 3 respectively.
- Multi-cycle op, MC_LAT=4: McStartE pulse -> StallE/McBusy/FlushM high for exactly 3 cycles, low on the 4th. A second McStartE during busy has no effect.
- Priority: PCSrcE=1 together with McStartE=1 and load-use match -> FlushD=FlushE=1, StallF=0, McBusy stays 0.
- Reset mid-op: rst_n low during MCBUSY cycle 2 -> all stall/flush outputs 0 immediately. After release, IDLE with StallCount=0.
- Saturation: PERF_W=4, force 20 load-use stalls -> StallCount holds at 15.
